// File: rtl/regs_writeback_if.sv
// ============================================================================
// Interface     : regs_writeback_if
// Description   : Writeback bus bundle: ALU result, load issue and load
//                 return handshake, rs1 hazard query, and the register-file
//                 write port. Signal prefixes are from the writeback block's
//                 point of view (slave modport).
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regs_writeback_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RW = $clog2(NREGS);

  logic            i_alu_valid;
  logic [RW-1:0]   i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            i_load_issue;
  logic [RW-1:0]   i_load_issue_rd;
  logic            i_load_valid;
  logic            o_load_ready;
  logic [RW-1:0]   i_load_rd;
  logic [XLEN-1:0] i_load_data;
  logic [RW-1:0]   i_rs1_select;
  logic            o_rs1_busy;
  logic            o_rs1_fwd_hit;
  logic [XLEN-1:0] o_rs1_fwd_data;
  logic [RW-1:0]   o_reg_write_select;
  logic [XLEN-1:0] o_reg_write_data;
  logic [31:0]     o_stall_count;

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_load_issue, i_load_issue_rd,
    output i_load_valid, i_load_rd, i_load_data,
    output i_rs1_select,
    input  o_load_ready, o_rs1_busy, o_rs1_fwd_hit, o_rs1_fwd_data,
    input  o_reg_write_select, o_reg_write_data, o_stall_count
  );

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_load_issue, i_load_issue_rd,
    input  i_load_valid, i_load_rd, i_load_data,
    input  i_rs1_select,
    output o_load_ready, o_rs1_busy, o_rs1_fwd_hit, o_rs1_fwd_data,
    output o_reg_write_select, o_reg_write_data, o_stall_count
  );
endinterface

`default_nettype wire

// File: rtl/regs_writeback.sv
// ============================================================================
// Module        : regs_writeback
// Description   : Arbitrates ALU results and returned loads onto the register
//                 file's single always-writing port, tracks pending loads for
//                 decode stalls, and registers a forwarding result for the
//                 file's read-before-write edge.
//                 Optional: define WB_PERF_EN to enable the saturating
//                 load-backpressure stall counter.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_writeback #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,   // asynchronous, active-low
  regs_writeback_if.slave   bus
);
  localparam int RW = $clog2(NREGS);

  logic             w_alu_write;
  logic             w_load_ready;
  logic             w_load_accept;
  logic             w_drain;
  logic [NREGS-1:0] w_busy_next;

  logic             r_buf_full;
  logic [RW-1:0]    r_buf_rd;
  logic [XLEN-1:0]  r_buf_data;
  logic [NREGS-1:0] r_busy;
  logic [RW-1:0]    r_wr_sel;
  logic [XLEN-1:0]  r_wr_data;
  logic             r_fwd_hit;
  logic [XLEN-1:0]  r_fwd_data;

  // rd=0 from the ALU is not a write, which lets the buffer drain that cycle
  assign w_alu_write   = bus.i_alu_valid && (bus.i_alu_rd != '0);
  assign w_load_ready  = !r_buf_full || !w_alu_write;
  assign w_load_accept = bus.i_load_valid && w_load_ready;
  assign w_drain       = r_buf_full && !w_alu_write;

  // Single-entry load buffer; a drain and a refill may share one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_full <= 1'b0;
      r_buf_rd   <= '0;
      r_buf_data <= '0;
    end else if (w_load_accept) begin
      r_buf_full <= 1'b1;
      r_buf_rd   <= bus.i_load_rd;
      r_buf_data <= bus.i_load_data;
    end else if (w_drain) begin
      r_buf_full <= 1'b0;
    end
  end

  // Write-port register: ALU first, then buffered load, else harmless x0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else if (w_alu_write) begin
      r_wr_sel  <= bus.i_alu_rd;
      r_wr_data <= bus.i_alu_data;
    end else if (w_drain) begin
      r_wr_sel  <= r_buf_rd;
      r_wr_data <= r_buf_data;
    end else begin
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end
  end

  // Scoreboard update: clear on drain, then set so a same-rd issue wins
  always_comb begin
    w_busy_next = r_busy;
    if (w_drain) begin
      w_busy_next[r_buf_rd] = 1'b0;
    end
    if (bus.i_load_issue && (bus.i_load_issue_rd != '0)) begin
      w_busy_next[bus.i_load_issue_rd] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Forwarding: the file reads the old value on the edge it writes rs1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= (r_wr_sel != '0) && (r_wr_sel == bus.i_rs1_select);
      r_fwd_data <= r_wr_data;
    end
  end

`ifdef WB_PERF_EN
  logic        w_stall;
  logic [31:0] r_stall_count;

  assign w_stall = bus.i_load_valid && !w_load_ready;

  // Saturating count of cycles a load was refused
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.o_stall_count = r_stall_count;
`else
  assign bus.o_stall_count = 32'd0;
`endif

  assign bus.o_load_ready       = w_load_ready;
  assign bus.o_rs1_busy         = (bus.i_rs1_select != '0) && r_busy[bus.i_rs1_select];
  assign bus.o_rs1_fwd_hit      = r_fwd_hit;
  assign bus.o_rs1_fwd_data     = r_fwd_data;
  assign bus.o_reg_write_select = r_wr_sel;
  assign bus.o_reg_write_data   = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_regs_writeback.sv
// ============================================================================
// Module        : tb_regs_writeback
// Description   : Directed bench for regs_writeback. Expected register-file
//                 writes (select, data, cycle) are queued by the stimulus and
//                 popped by a monitor whenever a nonzero select appears.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regs_writeback;
  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  regs_writeback_if #(.XLEN(32), .NREGS(32)) bus ();

  regs_writeback #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every real write must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.o_reg_write_select != 5'd0) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL wr_unexpected: got sel=%0d data=%h cyc=%0d, required no write",
                 bus.o_reg_write_select, bus.o_reg_write_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.o_reg_write_select !== mon_e.sel || bus.o_reg_write_data !== mon_e.data ||
            cyc != mon_e.cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL wr_port: got sel=%0d data=%h cyc=%0d, required sel=%0d data=%h cyc=%0d",
                   bus.o_reg_write_select, bus.o_reg_write_data, cyc,
                   mon_e.sel, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] s, input logic [31:0] d, input int c);
    wr_t e;
    e.sel  = s;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc    = 0;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.i_alu_valid     = 1'b0;
    bus.i_alu_rd        = '0;
    bus.i_alu_data      = '0;
    bus.i_load_issue    = 1'b0;
    bus.i_load_issue_rd = '0;
    bus.i_load_valid    = 1'b0;
    bus.i_load_rd       = '0;
    bus.i_load_data     = '0;
    bus.i_rs1_select    = '0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_sel",      32'(bus.o_reg_write_select), 32'd0);
    chk("rst_data",     bus.o_reg_write_data, 32'd0);
    chk("rst_fwd_hit",  32'(bus.o_rs1_fwd_hit), 32'd0);
    chk("rst_fwd_data", bus.o_rs1_fwd_data, 32'd0);
    chk("rst_stall",    bus.o_stall_count, 32'd0);
    chk("rst_ready",    32'(bus.o_load_ready), 32'd1);
    reset = 1'b1;
    tick();
    bus.i_rs1_select = 5'd7;
    #1;
    chk("idle_busy7", 32'(bus.o_rs1_busy), 32'd0);
    chk("idle_ready", 32'(bus.o_load_ready), 32'd1);

    // ALU write, then forwarding hit on rd=5 and x0 never hits
    tick();
    bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'h1234;
    push(5'd5, 32'h1234, cyc + 1);
    tick();
    bus.i_alu_valid = 1'b0; bus.i_rs1_select = 5'd5;
    tick();
    #1;
    chk("alu_sel_clear", 32'(bus.o_reg_write_select), 32'd0);
    chk("fwd_hit5",      32'(bus.o_rs1_fwd_hit), 32'd1);
    chk("fwd_data5",     bus.o_rs1_fwd_data, 32'h1234);
    bus.i_rs1_select = 5'd0;
    tick();
    #1;
    chk("fwd_hit_x0", 32'(bus.o_rs1_fwd_hit), 32'd0);

    // Load rd=7: busy until the write reaches the port
    tick();
    bus.i_load_issue = 1'b1; bus.i_load_issue_rd = 5'd7; bus.i_rs1_select = 5'd7;
    tick();
    bus.i_load_issue = 1'b0;
    bus.i_load_valid = 1'b1; bus.i_load_rd = 5'd7; bus.i_load_data = 32'hCAFE;
    push(5'd7, 32'hCAFE, cyc + 2);
    #1;
    chk("ld_busy7_a", 32'(bus.o_rs1_busy), 32'd1);
    chk("ld_ready",   32'(bus.o_load_ready), 32'd1);
    tick();
    bus.i_load_valid = 1'b0;
    #1;
    chk("ld_busy7_b", 32'(bus.o_rs1_busy), 32'd1);
    tick();
    #1;
    chk("ld_busy7_clr", 32'(bus.o_rs1_busy), 32'd0);

    // ALU burst starves a held load; second load waits
    tick();
    bus.i_load_valid = 1'b1; bus.i_load_rd = 5'd3; bus.i_load_data = 32'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd9; bus.i_alu_data = 32'h900 + 32'(i);
      bus.i_load_valid = 1'b1; bus.i_load_rd = 5'd11; bus.i_load_data = 32'hBB;
      push(5'd9, 32'h900 + 32'(i), cyc + 1);
      #1;
      chk("starve_ready0", 32'(bus.o_load_ready), 32'd0);
    end
    tick();
    bus.i_alu_valid = 1'b0;
    push(5'd3, 32'h33, cyc + 1);
    push(5'd11, 32'hBB, cyc + 2);
    #1;
    chk("starve_ready1", 32'(bus.o_load_ready), 32'd1);
    tick();
    bus.i_load_valid = 1'b0;
    #1;
`ifdef WB_PERF_EN
    chk("stall_count", bus.o_stall_count, 32'd3);
`else
    chk("stall_count", bus.o_stall_count, 32'd0);
`endif

    // ALU to x0 lets a full buffer drain
    tick();
    tick();
    bus.i_load_valid = 1'b1; bus.i_load_rd = 5'd12; bus.i_load_data = 32'hC0;
    tick();
    bus.i_load_valid = 1'b0;
    bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd0; bus.i_alu_data = 32'hDEAD;
    push(5'd12, 32'hC0, cyc + 1);
    #1;
    chk("x0_ready", 32'(bus.o_load_ready), 32'd1);
    tick();
    bus.i_alu_valid = 1'b0;

    // Forwarding on rd=4
    tick();
    bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd4; bus.i_alu_data = 32'h4444;
    bus.i_rs1_select = 5'd4;
    push(5'd4, 32'h4444, cyc + 1);
    tick();
    bus.i_alu_valid = 1'b0;
    tick();
    #1;
    chk("fwd_hit4",  32'(bus.o_rs1_fwd_hit), 32'd1);
    chk("fwd_data4", bus.o_rs1_fwd_data, 32'h4444);

    // Set and clear of rd=6 on the same edge: set wins
    tick();
    bus.i_load_issue = 1'b1; bus.i_load_issue_rd = 5'd6; bus.i_rs1_select = 5'd6;
    tick();
    bus.i_load_issue = 1'b0;
    bus.i_load_valid = 1'b1; bus.i_load_rd = 5'd6; bus.i_load_data = 32'h66;
    tick();
    bus.i_load_valid = 1'b0;
    bus.i_load_issue = 1'b1; bus.i_load_issue_rd = 5'd6;
    push(5'd6, 32'h66, cyc + 1);
    tick();
    bus.i_load_issue = 1'b0;
    #1;
    chk("setwins_busy6", 32'(bus.o_rs1_busy), 32'd1);

    // Reset with a load held in the buffer
    tick();
    bus.i_load_issue = 1'b1; bus.i_load_issue_rd = 5'd8; bus.i_rs1_select = 5'd8;
    tick();
    bus.i_load_issue = 1'b0;
    bus.i_load_valid = 1'b1; bus.i_load_rd = 5'd8; bus.i_load_data = 32'h88;
    tick();
    bus.i_load_valid = 1'b0;
    bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd2; bus.i_alu_data = 32'h22;
    push(5'd2, 32'h22, cyc + 1);
    #1;
    chk("rstbuf_busy8", 32'(bus.o_rs1_busy), 32'd1);
    tick();
    bus.i_alu_data = 32'h23;
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.i_alu_valid = 1'b0;
    #1;
    chk("rstbuf_busy8_clr", 32'(bus.o_rs1_busy), 32'd0);
    bus.i_rs1_select = 5'd6;
    #1;
    chk("rstbuf_busy6_clr", 32'(bus.o_rs1_busy), 32'd0);
    chk("rstbuf_sel",       32'(bus.o_reg_write_select), 32'd0);
    tick();
    reset = 1'b1;
    repeat (4) tick();

    // Every queued write must have appeared
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
